// File: rtl/exu_wb_arbiter.sv
// Write-back collector: merges ALU/MUL/DIV/LSU results onto the single register-file write port.
// Collisions are parked in one pending slot per source, and wb_stall holds off decode while any slot is full.
module exu_wb_arbiter #(
  parameter int unsigned XLEN                = 32,
  parameter int unsigned REG_FILE_ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           alu_wb_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] alu_wb_rd_addr,
  input  logic [XLEN-1:0]                alu_wb_data,
  input  logic                           mul_wb_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] mul_wb_rd_addr,
  input  logic [XLEN-1:0]                mul_wb_data,
  input  logic                           div_wb_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] div_wb_rd_addr,
  input  logic [XLEN-1:0]                div_wb_data,
  input  logic                           lsu_wb_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] lsu_wb_rd_addr,
  input  logic [XLEN-1:0]                lsu_wb_data,
  output logic [XLEN-1:0]                exu_wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0] exu_wb_rd_addr,
  output logic                           exu_wb_rd_wr_en,
  output logic                           wb_stall,
  output logic                           wb_overflow
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned AW   = REG_FILE_ADDR_WIDTH;

  // Source index doubles as priority: 3 = LSU (highest) down to 0 = ALU.
  logic [NSRC-1:0]           in_v;
  logic [NSRC-1:0][AW-1:0]   in_a;
  logic [NSRC-1:0][XLEN-1:0] in_d;
  logic [NSRC-1:0]           live_v;

  assign in_v = {lsu_wb_valid, div_wb_valid, mul_wb_valid, alu_wb_valid};
  assign in_a = {lsu_wb_rd_addr, div_wb_rd_addr, mul_wb_rd_addr, alu_wb_rd_addr};
  assign in_d = {lsu_wb_data, div_wb_data, mul_wb_data, alu_wb_data};

  logic [NSRC-1:0]           pend_v_q, pend_v_d;
  logic [NSRC-1:0][AW-1:0]   pend_a_q, pend_a_d;
  logic [NSRC-1:0][XLEN-1:0] pend_d_q, pend_d_d;
  logic [XLEN-1:0]           wb_data_q, wb_data_d;
  logic [AW-1:0]             wb_addr_q, wb_addr_d;
  logic                      wb_en_q, wb_en_d;
  logic                      stall_q, stall_d;
  logic                      ovf_q, ovf_d;

  logic [NSRC-1:0] cand_v;
  logic            gnt_any;
  logic [1:0]      gnt_idx;
  logic            granted;

  // Grant, output-register and pending-slot next state.
  always_comb begin
    pend_v_d  = pend_v_q;
    pend_a_d  = pend_a_q;
    pend_d_d  = pend_d_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    wb_en_d   = 1'b0;
    ovf_d     = ovf_q;
    gnt_any   = 1'b0;
    gnt_idx   = 2'd0;
    granted   = 1'b0;

    // Writes to x0 are architecturally void, so they never enter arbitration.
    for (int unsigned s = 0; s < NSRC; s++) begin
      live_v[s] = in_v[s] && (in_a[s] != '0);
    end
    cand_v = pend_v_q | live_v;

    for (int unsigned s = 0; s < NSRC; s++) begin
      if (cand_v[s]) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(s);
      end
    end

    if (gnt_any) begin
      wb_en_d   = 1'b1;
      wb_data_d = pend_v_q[gnt_idx] ? pend_d_q[gnt_idx] : in_d[gnt_idx];
      wb_addr_d = pend_v_q[gnt_idx] ? pend_a_q[gnt_idx] : in_a[gnt_idx];
    end

    for (int unsigned s = 0; s < NSRC; s++) begin
      granted = gnt_any && (gnt_idx == 2'(s));
      if (granted) begin
        if (pend_v_q[s]) begin
          pend_v_d[s] = live_v[s];
          if (live_v[s]) begin
            pend_a_d[s] = in_a[s];
            pend_d_d[s] = in_d[s];
          end
        end
      end else if (live_v[s]) begin
        // A full slot keeps the older result; the newer one is lost.
        if (pend_v_q[s]) begin
          ovf_d = 1'b1;
        end else begin
          pend_v_d[s] = 1'b1;
          pend_a_d[s] = in_a[s];
          pend_d_d[s] = in_d[s];
        end
      end
    end

    stall_d = |pend_v_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_v_q  <= '0;
      pend_a_q  <= '0;
      pend_d_q  <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      wb_en_q   <= 1'b0;
      stall_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_a_q  <= pend_a_d;
      pend_d_q  <= pend_d_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_en_q   <= wb_en_d;
      stall_q   <= stall_d;
      ovf_q     <= ovf_d;
    end
  end

  assign exu_wb_data     = wb_data_q;
  assign exu_wb_rd_addr  = wb_addr_q;
  assign exu_wb_rd_wr_en = wb_en_q;
  assign wb_stall        = stall_q;
  assign wb_overflow     = ovf_q;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Scoreboard bench for exu_wb_arbiter: directed collision, x0, refill, overflow and reset scenarios.
module tb_exu_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic            alu_wb_valid, mul_wb_valid, div_wb_valid, lsu_wb_valid;
  logic [AW-1:0]   alu_wb_rd_addr, mul_wb_rd_addr, div_wb_rd_addr, lsu_wb_rd_addr;
  logic [XLEN-1:0] alu_wb_data, mul_wb_data, div_wb_data, lsu_wb_data;
  logic [XLEN-1:0] exu_wb_data;
  logic [AW-1:0]   exu_wb_rd_addr;
  logic            exu_wb_rd_wr_en;
  logic            wb_stall;
  logic            wb_overflow;

  exu_wb_arbiter #(.XLEN(XLEN), .REG_FILE_ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .alu_wb_valid    (alu_wb_valid),
    .alu_wb_rd_addr  (alu_wb_rd_addr),
    .alu_wb_data     (alu_wb_data),
    .mul_wb_valid    (mul_wb_valid),
    .mul_wb_rd_addr  (mul_wb_rd_addr),
    .mul_wb_data     (mul_wb_data),
    .div_wb_valid    (div_wb_valid),
    .div_wb_rd_addr  (div_wb_rd_addr),
    .div_wb_data     (div_wb_data),
    .lsu_wb_valid    (lsu_wb_valid),
    .lsu_wb_rd_addr  (lsu_wb_rd_addr),
    .lsu_wb_data     (lsu_wb_data),
    .exu_wb_data     (exu_wb_data),
    .exu_wb_rd_addr  (exu_wb_rd_addr),
    .exu_wb_rd_wr_en (exu_wb_rd_wr_en),
    .wb_stall        (wb_stall),
    .wb_overflow     (wb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  passes = 0;

  function automatic void check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  wr_t mon_e;
  always @(negedge clk) begin
    if (rstn === 1'b1 && exu_wb_rd_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                 exu_wb_rd_addr, exu_wb_data);
      end else begin
        mon_e = sb.pop_front();
        check("wb_addr", XLEN'(exu_wb_rd_addr), XLEN'(mon_e.a));
        check("wb_data", exu_wb_data, mon_e.d);
      end
    end
  end

  task automatic clear_inputs();
    alu_wb_valid = 1'b0; alu_wb_rd_addr = '0; alu_wb_data = '0;
    mul_wb_valid = 1'b0; mul_wb_rd_addr = '0; mul_wb_data = '0;
    div_wb_valid = 1'b0; div_wb_rd_addr = '0; div_wb_data = '0;
    lsu_wb_valid = 1'b0; lsu_wb_rd_addr = '0; lsu_wb_data = '0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic check_drained(string name);
    check(name, XLEN'(sb.size()), XLEN'(0));
    sb.delete();
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    step(2);
    check("rst_wr_en", XLEN'(exu_wb_rd_wr_en), 0);
    check("rst_addr", XLEN'(exu_wb_rd_addr), 0);
    check("rst_data", exu_wb_data, 0);
    check("rst_stall", XLEN'(wb_stall), 0);
    check("rst_overflow", XLEN'(wb_overflow), 0);
    rstn = 1'b1;
    step(1);

    // 1: ALU only
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd5; alu_wb_data = 32'h1234_5678;
    expect_wr(5'd5, 32'h1234_5678);
    step(1);
    clear_inputs();
    check("t1_stall", XLEN'(wb_stall), 0);
    step(3);
    check_drained("t1_drain");

    // 2: four-way collision, LSU > DIV > MUL > ALU
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd1; alu_wb_data = 32'hA1A1_0001;
    mul_wb_valid = 1'b1; mul_wb_rd_addr = 5'd2; mul_wb_data = 32'hB2B2_0002;
    div_wb_valid = 1'b1; div_wb_rd_addr = 5'd3; div_wb_data = 32'hC3C3_0003;
    lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd4; lsu_wb_data = 32'hD4D4_0004;
    expect_wr(5'd4, 32'hD4D4_0004);
    expect_wr(5'd3, 32'hC3C3_0003);
    expect_wr(5'd2, 32'hB2B2_0002);
    expect_wr(5'd1, 32'hA1A1_0001);
    step(1);
    clear_inputs();
    check("t2_stall_c1", XLEN'(wb_stall), 1);
    step(1);
    check("t2_stall_c2", XLEN'(wb_stall), 1);
    step(1);
    check("t2_stall_c3", XLEN'(wb_stall), 1);
    step(1);
    check("t2_stall_c4", XLEN'(wb_stall), 0);
    step(2);
    check_drained("t2_drain");

    // 3: x0 filter
    mul_wb_valid = 1'b1; mul_wb_rd_addr = 5'd0; mul_wb_data = 32'hFFFF_FFFF;
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd7; alu_wb_data = 32'h0000_0777;
    expect_wr(5'd7, 32'h0000_0777);
    step(1);
    clear_inputs();
    check("t3_stall", XLEN'(wb_stall), 0);
    check("t3_overflow", XLEN'(wb_overflow), 0);
    step(3);
    check_drained("t3_drain");

    // 4: refill ALU slot while it drains
    lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd8; lsu_wb_data = 32'h8888_0008;
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd6; alu_wb_data = 32'h6666_0006;
    expect_wr(5'd8, 32'h8888_0008);
    expect_wr(5'd6, 32'h6666_0006);
    expect_wr(5'd9, 32'h9999_0009);
    step(1);
    clear_inputs();
    check("t4_stall_c1", XLEN'(wb_stall), 1);
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd9; alu_wb_data = 32'h9999_0009;
    step(1);
    clear_inputs();
    check("t4_stall_c2", XLEN'(wb_stall), 1);
    step(1);
    check("t4_stall_c3", XLEN'(wb_stall), 0);
    step(2);
    check("t4_overflow", XLEN'(wb_overflow), 0);
    check_drained("t4_drain");

    // 5: overflow, second ALU result dropped
    lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd10; lsu_wb_data = 32'h0A0A_000A;
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd11; alu_wb_data = 32'h0B0B_000B;
    expect_wr(5'd10, 32'h0A0A_000A);
    step(1);
    check("t5_overflow_c1", XLEN'(wb_overflow), 0);
    lsu_wb_rd_addr = 5'd12; lsu_wb_data = 32'h0C0C_000C;
    alu_wb_rd_addr = 5'd13; alu_wb_data = 32'h0D0D_000D;
    expect_wr(5'd12, 32'h0C0C_000C);
    step(1);
    check("t5_overflow_c2", XLEN'(wb_overflow), 1);
    check("t5_stall_c2", XLEN'(wb_stall), 1);
    alu_wb_valid = 1'b0; alu_wb_rd_addr = '0; alu_wb_data = '0;
    lsu_wb_rd_addr = 5'd14; lsu_wb_data = 32'h0E0E_000E;
    expect_wr(5'd14, 32'h0E0E_000E);
    expect_wr(5'd11, 32'h0B0B_000B);
    step(1);
    clear_inputs();
    step(3);
    check("t5_overflow_sticky", XLEN'(wb_overflow), 1);
    check_drained("t5_drain");

    // 6: reset mid-collision discards pending results
    alu_wb_valid = 1'b1; alu_wb_rd_addr = 5'd1; alu_wb_data = 32'hA1A1_0001;
    mul_wb_valid = 1'b1; mul_wb_rd_addr = 5'd2; mul_wb_data = 32'hB2B2_0002;
    div_wb_valid = 1'b1; div_wb_rd_addr = 5'd3; div_wb_data = 32'hC3C3_0003;
    lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd4; lsu_wb_data = 32'hD4D4_0004;
    expect_wr(5'd4, 32'hD4D4_0004);
    step(1);
    clear_inputs();
    step(1);
    rstn = 1'b0;
    #1;
    check("t6_wr_en", XLEN'(exu_wb_rd_wr_en), 0);
    check("t6_addr", XLEN'(exu_wb_rd_addr), 0);
    check("t6_data", exu_wb_data, 0);
    check("t6_stall", XLEN'(wb_stall), 0);
    check("t6_overflow", XLEN'(wb_overflow), 0);
    step(1);
    rstn = 1'b1;
    step(6);
    check("t6_stall_after", XLEN'(wb_stall), 0);
    check_drained("t6_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exu_wb_arbiter.md
Name: exu_wb_arbiter

Overview:
Write-back collector at the tail of the EXU. It merges results from the ALU, MUL, DIV and LSU into the single register-file write-back port consumed by decode (exu_wb_data / exu_wb_rd_addr / exu_wb_rd_wr_en). At most one write per cycle. Colliding results are held in per-source pending slots, and decode is back-pressured through wb_stall.

Parameters:
XLEN, 32, data width
REG_FILE_ADDR_WIDTH, 5, register address width

Ports:
clk  in  1  core clock
rstn  in  1  reset; asynchronous, active-low
alu_wb_valid  in  1  ALU result valid this cycle
alu_wb_rd_addr  in  REG_FILE_ADDR_WIDTH  ALU destination
alu_wb_data  in  XLEN  ALU result
mul_wb_valid / mul_wb_rd_addr / mul_wb_data  in  1 / RFAW / XLEN  MUL result
div_wb_valid / div_wb_rd_addr / div_wb_data  in  1 / RFAW / XLEN  DIV result
lsu_wb_valid / lsu_wb_rd_addr / lsu_wb_data  in  1 / RFAW / XLEN  load result
exu_wb_data  out  XLEN  write-back data to register file
exu_wb_rd_addr  out  REG_FILE_ADDR_WIDTH  write-back address
exu_wb_rd_wr_en  out  1  write-back strobe
wb_stall  out  1  any pending slot occupied; decode must not issue
wb_overflow  out  1  sticky error: a result was dropped

Behaviour:
- Reset (rstn low, asynchronous): all pending slots invalid. exu_wb_data = 0, exu_wb_rd_addr = 0, exu_wb_rd_wr_en = 0, wb_overflow = 0. A reset asserted mid-operation discards all pending results immediately.
- x0 filter: a live input with valid = 1 and rd_addr = 0 is discarded. It is never captured, never granted and never counted as overflow. exu_wb_rd_wr_en is never 1 with exu_wb_rd_addr = 0.
- Per-source candidate: if pending_s is valid, the candidate is the pending entry; otherwise it is the filtered live input.
- Grant: fixed priority LSU > DIV > MUL > ALU among valid candidates, one grant per cycle.
- Output register: the granted candidate is registered into exu_wb_* on the next clk edge (latency 1) with exu_wb_rd_wr_en = 1.
- No grant: exu_wb_rd_wr_en = 0 next cycle; exu_wb_data and exu_wb_rd_addr hold their last values.
- Pending update for each source s, each cycle:
  - Granted from pending, no live input: slot clears.
  - Granted from pending, live valid input present: live input is captured into the slot.
  - Granted from live input: slot stays empty.
  - Not granted, candidate was live: live input is captured.
  - Not granted, slot already full, and a new live valid arrives: the live result is dropped, the slot keeps the older entry, and wb_overflow sets. wb_overflow stays set until reset.
- wb_stall = OR of pending valid bits. It is registered state, so it is glitch-free.
- Sources accept no backpressure. Issue rules in the core guarantee at most one outstanding result per source beyond its slot; overflow flags a violation of that rule.
- Ordering: two results to the same rd in flight at once are not reordered or checked. The later grant overwrites the earlier one.
- No flush input: results that have completed always commit.

Test Plan:
1. ALU only: alu valid, rd = 5, data = 0x12345678 at cycle 0 -> cycle 1: wr_en = 1, addr = 5, data = 0x12345678; wb_stall stays 0.
2. Four-way collision: all four valid at cycle 0 with rd = 1 (alu), 2 (mul), 3 (div), 4 (lsu) -> wr_en high in cycles 1 through 4 with addr order 4, 3, 2, 1; wb_stall = 1 in cycles 1 through 3 and 0 from cycle 4.
3. x0 filter: mul valid, rd = 0, data = 0xFFFFFFFF together with alu rd = 7 -> only addr 7 is written at cycle 1; no pending entry; wb_stall stays 0.
4. Refill while draining: lsu + alu collide at cycle 0 (alu held); alu valid again at cycle 1 with rd = 9 -> cycle 2 writes the held alu result, cycle 3 writes rd = 9; no overflow.
5. Overflow: lsu valid in cycles 0, 1 and 2 with alu valid in cycles 0 and 1 -> the second alu result is dropped, wb_overflow = 1 from cycle 2 and stays high; the first alu result is written after the lsu stream ends.
6. Reset mid-operation: after the scenario 2 stimulus, drop rstn at cycle 2 -> outputs are 0 and wb_stall = 0 immediately; no further writes after rstn releases.
